// File: rtl/rr_arbiter_3to8.sv
// rr_arbiter_3to8
//   Round-robin arbiter that gives one of 8 requesters exclusive use of a
//   3-to-8 decoded resource. A grant is a 3-bit index plus the matching
//   one-hot vector. The owner keeps the grant until it pulses done or drops
//   its request line. Every grant is followed by at least one idle cycle.
//
//   Optional feature: define RR_ARB_TIMEOUT_EN to enable a hold counter. A
//   grant held for TIMEOUT cycles is then forcibly released, and timeout
//   pulses for one cycle. Without the macro, timeout is constant 0.
//
// Parameters:
//   TIMEOUT    maximum grant hold time in cycles, 1..255
//              (only used with RR_ARB_TIMEOUT_EN)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req[7:0]   request lines, bit i = requester i
//   done       single-cycle pulse: the current owner has finished
//   gnt_idx    index of the granted requester (stale when gnt_valid=0)
//   gnt[7:0]   one-hot grant, 1 << gnt_idx while gnt_valid, else 0
//   gnt_valid  a grant is active
//   timeout    one-cycle pulse on a forced release
module rr_arbiter_3to8 #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [2:0] gnt_idx,
  output logic [7:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state_reg, state_next;
  logic [2:0] last_reg, last_next;
  logic [2:0] idx_reg, idx_next;
  logic [7:0] gnt_reg, gnt_next;
  logic       valid_reg, valid_next;
  logic       timeout_reg, timeout_next;

  logic [2:0] rot_sel [8];
  logic [7:0] rot_req;
  logic [2:0] pick_off;
  logic [2:0] pick_idx;
  logic       pick_any;
  logic       limit_hit;
  logic       release_now;

  // Reject an out-of-range TIMEOUT when the design is elaborated.
  generate
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range_check
      $error("rr_arbiter_3to8: TIMEOUT must be in 1..255");
    end
  endgenerate

  // Rotate the request vector so that position 0 holds the requester just
  // after the last winner. A fixed-priority pick on the rotated vector is
  // then a round-robin pick on the original one.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_rotate
      assign rot_sel[gi] = last_reg + 3'(gi + 1);
      assign rot_req[gi] = req[rot_sel[gi]];
    end
  endgenerate

  // Scan downward so that the lowest set rotated position wins.
  always_comb begin
    pick_off = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (rot_req[k]) begin
        pick_off = 3'(k);
      end
    end
  end

  assign pick_any = |req;
  assign pick_idx = rot_sel[pick_off];

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] count_reg, count_next;

  // Reaching TIMEOUT-1 forces release on the next edge, so a grant is
  // visible for exactly TIMEOUT cycles.
  assign limit_hit = (state_reg == GRANT) && (count_reg == HOLD_LIMIT);

  always_comb begin
    count_next = count_reg;
    if (state_reg == IDLE) begin
      if (pick_any) begin
        count_next = 8'd0;
      end
    end else if (!release_now) begin
      count_next = count_reg + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= 8'd0;
    end else begin
      count_reg <= count_next;
    end
  end
`else
  assign limit_hit = 1'b0;
`endif

  // A withdrawn request counts as a release, the same as done.
  assign release_now = done | ~req[idx_reg] | limit_hit;

  always_comb begin
    state_next   = state_reg;
    last_next    = last_reg;
    idx_next     = idx_reg;
    gnt_next     = gnt_reg;
    valid_next   = valid_reg;
    timeout_next = 1'b0;
    case (state_reg)
      IDLE: begin
        // done arriving here is deliberately ignored.
        if (pick_any) begin
          state_next = GRANT;
          idx_next   = pick_idx;
          gnt_next   = 8'b0000_0001 << pick_idx;
          valid_next = 1'b1;
          last_next  = pick_idx;
        end
      end
      GRANT: begin
        // Requests from other lines are not looked at here. They are
        // arbitrated in the idle cycle that follows the release.
        if (release_now) begin
          state_next   = IDLE;
          gnt_next     = 8'h00;
          valid_next   = 1'b0;
          timeout_next = limit_hit;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 8'h00;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      last_reg    <= 3'd7;
      idx_reg     <= 3'd0;
      gnt_reg     <= 8'h00;
      valid_reg   <= 1'b0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      last_reg    <= last_next;
      idx_reg     <= idx_next;
      gnt_reg     <= gnt_next;
      valid_reg   <= valid_next;
      timeout_reg <= timeout_next;
    end
  end

  assign gnt_idx   = idx_reg;
  assign gnt       = gnt_reg;
  assign gnt_valid = valid_reg;
  assign timeout   = timeout_reg;

endmodule

// File: tb/tb_rr_arbiter_3to8.sv
// Directed testbench for rr_arbiter_3to8. Inputs are driven 1 time unit
// after each rising edge. Outputs are checked at the same point, so they
// show the result of the edge that has just occurred.
module tb_rr_arbiter_3to8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] gnt_idx;
  logic [7:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_arbiter_3to8 #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Check all outputs. The index is checked only while a grant is expected.
  task automatic chk_out(input string tag, input logic v, input logic [2:0] idx,
                         input logic [7:0] g, input logic t);
    $display("[TB] %s: valid=%0b idx=%0d gnt=%02h timeout=%0b",
             tag, gnt_valid, gnt_idx, gnt, timeout);
    chk({tag, ".valid"}, {7'd0, gnt_valid}, {7'd0, v});
    chk({tag, ".gnt"}, gnt, g);
    chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
    if (v) begin
      chk({tag, ".idx"}, {5'd0, gnt_idx}, {5'd0, idx});
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Assert reset away from a clock edge, check that the outputs clear at
  // once, then release reset 1 unit after a rising edge.
  task automatic do_reset;
    #2;
    rst_n = 1'b0;
    req   = 8'h00;
    done  = 1'b0;
    #1;
    chk_out("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  initial begin
    // Power-on reset. Start high so that a real falling edge occurs.
    #1 rst_n = 1'b0;
    #1;
    chk_out("por", 1'b0, 3'd0, 8'h00, 1'b0);
    chk("por.idx", {5'd0, gnt_idx}, 8'h00);
    tick;
    tick;
    rst_n = 1'b1;

    // No requests: stay idle.
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_out("idle_noreq", 1'b0, 3'd0, 8'h00, 1'b0);
    end

    // Single requester 0, then done.
    req = 8'h01;
    tick;
    chk_out("single_grant0", 1'b1, 3'd0, 8'h01, 1'b0);
    done = 1'b1;
    tick;
    chk_out("single_done", 1'b0, 3'd0, 8'h00, 1'b0);
    done = 1'b0;
    req  = 8'h00;
    tick;
    chk_out("single_idle", 1'b0, 3'd0, 8'h00, 1'b0);

    // All requesting: order is 0..7,0, with one idle cycle between grants.
    do_reset;
    req = 8'hFF;
    for (int i = 0; i < 9; i++) begin
      logic [2:0] e_idx;
      e_idx = 3'(i % 8);
      tick;
      chk_out("rr_grant", 1'b1, e_idx, 8'h01 << e_idx, 1'b0);
      done = 1'b1;
      tick;
      chk_out("rr_gap", 1'b0, 3'd0, 8'h00, 1'b0);
      done = 1'b0;
    end

    // Wrap-around: the last grant is 5, then req=21 picks 0 and then 5.
    do_reset;
    req = 8'h20;
    tick;
    chk_out("wrap_first5", 1'b1, 3'd5, 8'h20, 1'b0);
    done = 1'b1;
    tick;
    chk_out("wrap_rel5", 1'b0, 3'd0, 8'h00, 1'b0);
    done = 1'b0;
    req  = 8'h21;
    tick;
    chk_out("wrap_pick0", 1'b1, 3'd0, 8'h01, 1'b0);
    done = 1'b1;
    tick;
    chk_out("wrap_rel0", 1'b0, 3'd0, 8'h00, 1'b0);
    done = 1'b0;
    tick;
    chk_out("wrap_pick5", 1'b1, 3'd5, 8'h20, 1'b0);

    // done while idle is ignored. Then withdrawal and asynchronous reset.
    do_reset;
    done = 1'b1;
    tick;
    chk_out("idle_done_ignored", 1'b0, 3'd0, 8'h00, 1'b0);
    done = 1'b0;
    req  = 8'h08;
    tick;
    chk_out("own3_grant", 1'b1, 3'd3, 8'h08, 1'b0);
    req = 8'h0F;
    tick;
    chk_out("own3_others_change", 1'b1, 3'd3, 8'h08, 1'b0);
    req = 8'h00;
    tick;
    chk_out("own3_withdraw", 1'b0, 3'd0, 8'h00, 1'b0);
    req = 8'h08;
    tick;
    chk_out("own3_regrant", 1'b1, 3'd3, 8'h08, 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_out("async_reset_midgrant", 1'b0, 3'd0, 8'h00, 1'b0);
    tick;
    tick;
    rst_n = 1'b1;
    req   = 8'hFF;
    tick;
    chk_out("ptr_back_to7", 1'b1, 3'd0, 8'h01, 1'b0);

`ifdef RR_ARB_TIMEOUT_EN
    // TIMEOUT=4: the grant is held 4 cycles, then force-released with a
    // timeout pulse, then regranted after one idle cycle.
    do_reset;
    req = 8'h04;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_out("to_hold", 1'b1, 3'd2, 8'h04, 1'b0);
    end
    tick;
    chk_out("to_release", 1'b0, 3'd0, 8'h00, 1'b1);
    tick;
    chk_out("to_regrant", 1'b1, 3'd2, 8'h04, 1'b0);
    // done and the timeout limit on the same cycle: one release, with the pulse.
    for (int i = 0; i < 3; i++) begin
      tick;
      chk_out("to_hold2", 1'b1, 3'd2, 8'h04, 1'b0);
    end
    done = 1'b1;
    tick;
    chk_out("to_done_same", 1'b0, 3'd0, 8'h00, 1'b1);
    done = 1'b0;
`else
    // Without the timeout feature, a grant persists indefinitely.
    do_reset;
    req = 8'h04;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk_out("no_to_hold", 1'b1, 3'd2, 8'h04, 1'b0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
